phase_generator: RTL and testbench
==================================

# phase_generator

Generates the CPU's two non-overlapping clock phases from `sys_clock` and the single-cycle edge strobes, chiefly `phase_2_rising`, that the program counter, registers and bus latches use to commit state. It sits directly upstream of the program counter and every other phase-qualified datapath block. It also implements the 6502 RDY read-stall, run/stop and single-step control, and keeps a completed-CPU-cycle counter for debug.

## Interface

**Parameters**
- `HALF_PERIOD`, default 4: `sys_clock` cycles each phase is held high. Legal range 2..255; out-of-range values are an elaboration error.

**Ports**
- `sys_clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; 1 = free-run CPU cycles.
- `step`  in  1  single-step request, acted on only in IDLE with `enable`=0.
- `rdy`  in  1  6502 RDY; 0 stalls read cycles.
- `rw`  in  1  current bus cycle direction: 1 = read, 0 = write.
- `phase_1`  out  1  phase 1 clock level.
- `phase_2`  out  1  phase 2 clock level.
- `phase_1_rising`  out  1  one-cycle strobe, coincident with the first cycle `phase_1` is high.
- `phase_2_rising`  out  1  one-cycle strobe, coincident with the first cycle `phase_2` is high.
- `phase_2_falling`  out  1  one-cycle strobe, in the first cycle after `phase_2` drops.
- `cycle_count`  out  16  completed CPU cycles, modulo 2^16.
- `halted`  out  1  high in IDLE or STALL.

## Operation

**Outputs.** All outputs are registered.

**States.** IDLE, PHI1, GAP12, PHI2, GAP21, STALL. An internal 8-bit phase counter times PHI1 and PHI2.
- **IDLE:** both phases low.
  - `enable`=1 → PHI1.
  - Else `step`=1 → PHI1, with the single-step flag set.
- **PHI1:** `phase_1`=1 for `HALF_PERIOD` cycles. `phase_1_rising` is asserted in the first cycle. At the last cycle:
  - `rdy`=0 and `rw`=1 → STALL.
  - Otherwise → GAP12.
- **STALL:** `phase_1` held at 1 and no strobes are issued. Leave to GAP12 on the first cycle `rdy`=1. `rw` is ignored while in STALL.
- **GAP12:** one cycle, both phases low → PHI2.
- **PHI2:** `phase_2`=1 for `HALF_PERIOD` cycles. `phase_2_rising` is asserted in the first cycle → GAP21.
- **GAP21:** one cycle, both phases low. `phase_2_falling`=1 and `cycle_count` increments in this cycle. Next state:
  - `enable`=1 and single-step flag clear → PHI1.
  - Otherwise → IDLE, and the single-step flag is cleared.

**Rules.**
- `rdy` only stalls reads. `rdy`=0 during a write cycle (`rw`=0) has no effect.
- Dropping `enable` mid-cycle never truncates a cycle. It takes effect only at GAP21.
- `step` is ignored outside IDLE and ignored while `enable`=1.
- `cycle_count` wraps 0xFFFF → 0x0000 with no flag.
- `phase_1` and `phase_2` are never high in the same cycle (non-overlap invariant).
- At most one strobe is high in any cycle.

## Timing

- **Reset:** asserting `reset` immediately and asynchronously forces IDLE, all outputs 0, `cycle_count`=0, phase counter=0 and single-step flag=0, including mid-cycle or mid-STALL. After release, `halted`=1.
- **Start latency:** `enable` sampled 1 at IDLE edge k → after edge k, `phase_1`=1 and `phase_1_rising`=1.
- **CPU cycle period:** 2·`HALF_PERIOD`+2 `sys_clock` cycles. With `HALF_PERIOD`=4 the cycle offsets are:
  - 0–3: PHI1 (strobe at 0)
  - 4: GAP12
  - 5–8: PHI2 (strobe at 5)
  - 9: GAP21 (`phase_2_falling`)
  - 10: next PHI1
- **STALL length:** each cycle spent in STALL extends PHI1 by one `sys_clock`. `rdy` sampled 1 at a STALL edge → GAP12 on the next edge.
- **`halted` timing:** follows the registered state, so it is valid in the same cycle as the state.

## Test plan

- **Free run:** reset low then high, `HALF_PERIOD`=4, `enable`=1, `rdy`=1. Expect:
  - a period of 10;
  - `phase_1_rising` at offsets 0 and 10, `phase_2_rising` at 5, `phase_2_falling` at 9;
  - phases never overlap;
  - `cycle_count`=3 after 30 cycles.
- **Read stall:** `rw`=1, `rdy`=0 at the last PHI1 cycle, held 0 for 6 cycles. Expect `phase_1` high for 4+6 cycles, `halted`=1 during STALL, no strobes, then `phase_2_rising` 2 cycles after `rdy` returns to 1. Repeat with `rw`=0: no stall, period 10.
- **Single step:** `enable`=0, one-cycle `step` pulse in IDLE. Expect exactly one full CPU cycle, `cycle_count`+1, return to IDLE, `halted`=1. A `step` pulse mid-cycle is ignored.
- **Stop mid-cycle:** `enable` dropped at offset 2. Expect the cycle to complete through `phase_2_falling`, then IDLE with both phases low.
- **Async reset in PHI2:** `reset` asserted at offset 6. Expect all outputs 0 and `cycle_count`=0 without waiting for a clock edge; a fresh PHI1 after release with `enable`=1.
- **Counter wrap:** preload to reach `cycle_count`=0xFFFF. Expect the next `phase_2_falling` to produce 0x0000.

Source files
------------

// File: rtl/phase_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : phase_generator
//  Description : Two-phase non-overlapping CPU clock generator with edge
//                strobes, RDY read-stall, run/stop, single-step control and
//                a completed-CPU-cycle debug counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_generator #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        step,
  input  logic        rdy,
  input  logic        rw,
  output logic        phase_1,
  output logic        phase_2,
  output logic        phase_1_rising,
  output logic        phase_2_rising,
  output logic        phase_2_falling,
  output logic [15:0] cycle_count,
  output logic        halted
);

  // Reject unusable half-period values at elaboration time.
  if ((HALF_PERIOD < 2) || (HALF_PERIOD > 255)) begin : g_bad_half_period
    $error("phase_generator: HALF_PERIOD must be in 2..255");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PHI1  = 3'd1;
  localparam logic [2:0] S_GAP12 = 3'd2;
  localparam logic [2:0] S_PHI2  = 3'd3;
  localparam logic [2:0] S_GAP21 = 3'd4;
  localparam logic [2:0] S_STALL = 3'd5;

  // Phase counter value in the final cycle of PHI1 / PHI2.
  localparam logic [7:0] C_LAST_CNT = 8'(HALF_PERIOD - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        step_flag_q, step_flag_d;

  logic        phase_1_q, phase_1_d;
  logic        phase_2_q, phase_2_d;
  logic        p1_rise_q, p1_rise_d;
  logic        p2_rise_q, p2_rise_d;
  logic        p2_fall_q, p2_fall_d;
  logic        halted_q, halted_d;
  logic [15:0] cycle_count_q, cycle_count_d;

  // Next-state logic: sequence through the phases, timing PHI1/PHI2 with cnt.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_flag_d = step_flag_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (enable) begin
          state_d = S_PHI1;
        end else if (step) begin
          state_d     = S_PHI1;
          step_flag_d = 1'b1;
        end
      end
      S_PHI1: begin
        if (cnt_q == C_LAST_CNT) begin
          cnt_d = 8'd0;
          // Only read cycles honour RDY; writes always proceed.
          state_d = (!rdy && rw) ? S_STALL : S_GAP12;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_STALL: begin
        if (rdy) begin
          state_d = S_GAP12;
        end
      end
      S_GAP12: begin
        cnt_d   = 8'd0;
        state_d = S_PHI2;
      end
      S_PHI2: begin
        if (cnt_q == C_LAST_CNT) begin
          cnt_d   = 8'd0;
          state_d = S_GAP21;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP21: begin
        cnt_d = 8'd0;
        // Run/stop decisions are made only here so a cycle is never truncated.
        if (enable && !step_flag_q) begin
          state_d = S_PHI1;
        end else begin
          state_d     = S_IDLE;
          step_flag_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cnt_d       = 8'd0;
        step_flag_d = 1'b0;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a register.
  always_comb begin
    phase_1_d     = (state_d == S_PHI1) || (state_d == S_STALL);
    phase_2_d     = (state_d == S_PHI2);
    p1_rise_d     = (state_d == S_PHI1) && (state_q != S_PHI1);
    p2_rise_d     = (state_d == S_PHI2) && (state_q != S_PHI2);
    p2_fall_d     = (state_d == S_GAP21);
    halted_d      = (state_d == S_IDLE) || (state_d == S_STALL);
    cycle_count_d = (state_d == S_GAP21) ? (cycle_count_q + 16'd1) : cycle_count_q;
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      step_flag_q   <= 1'b0;
      phase_1_q     <= 1'b0;
      phase_2_q     <= 1'b0;
      p1_rise_q     <= 1'b0;
      p2_rise_q     <= 1'b0;
      p2_fall_q     <= 1'b0;
      halted_q      <= 1'b0;
      cycle_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      step_flag_q   <= step_flag_d;
      phase_1_q     <= phase_1_d;
      phase_2_q     <= phase_2_d;
      p1_rise_q     <= p1_rise_d;
      p2_rise_q     <= p2_rise_d;
      p2_fall_q     <= p2_fall_d;
      halted_q      <= halted_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign phase_1         = phase_1_q;
  assign phase_2         = phase_2_q;
  assign phase_1_rising  = p1_rise_q;
  assign phase_2_rising  = p2_rise_q;
  assign phase_2_falling = p2_fall_q;
  assign cycle_count     = cycle_count_q;
  assign halted          = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_phase_generator
//  Description : Scoreboard bench for phase_generator against an offset-based
//                reference model of the CPU cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_generator;

  localparam int HP = 4;

  typedef struct packed {
    logic        p1;
    logic        p2;
    logic        p1r;
    logic        p2r;
    logic        p2f;
    logic        halted;
    logic [15:0] cnt;
  } out_t;

  logic        sys_clock = 1'b0;
  logic        reset     = 1'b0;
  logic        enable    = 1'b0;
  logic        step      = 1'b0;
  logic        rdy       = 1'b1;
  logic        rw        = 1'b1;
  logic        phase_1, phase_2, phase_1_rising, phase_2_rising, phase_2_falling;
  logic [15:0] cycle_count;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;
  out_t exp_q[$];

  // Reference model: position within the CPU cycle (0 .. 2*HP+1).
  bit          m_run   = 1'b0;
  bit          m_stall = 1'b0;
  bit          m_step  = 1'b0;
  int          m_pos   = 0;
  logic [15:0] m_cnt   = 16'd0;

  phase_generator #(.HALF_PERIOD(HP)) dut (
    .sys_clock       (sys_clock),
    .reset           (reset),
    .enable          (enable),
    .step            (step),
    .rdy             (rdy),
    .rw              (rw),
    .phase_1         (phase_1),
    .phase_2         (phase_2),
    .phase_1_rising  (phase_1_rising),
    .phase_2_rising  (phase_2_rising),
    .phase_2_falling (phase_2_falling),
    .cycle_count     (cycle_count),
    .halted          (halted)
  );

  always #5 sys_clock = ~sys_clock;

  function automatic out_t dut_out();
    return {phase_1, phase_2, phase_1_rising, phase_2_rising, phase_2_falling, halted, cycle_count};
  endfunction

  function automatic out_t model_out();
    out_t o;
    o = '0;
    if (!reset) return o;
    o.cnt = m_cnt;
    if (!m_run) begin
      o.halted = 1'b1;
    end else begin
      o.p1     = (m_pos < HP);
      o.p2     = (m_pos > HP) && (m_pos <= 2 * HP);
      o.p1r    = (m_pos == 0);
      o.p2r    = (m_pos == HP + 1);
      o.p2f    = (m_pos == 2 * HP + 1);
      o.halted = m_stall;
    end
    return o;
  endfunction

  // Advance the model by one sys_clock edge using the inputs sampled at it.
  function automatic void model_step();
    if (!reset) begin
      m_run = 0; m_stall = 0; m_step = 0; m_pos = 0; m_cnt = 16'd0;
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1; m_pos = 0;
      end else if (step) begin
        m_run = 1; m_pos = 0; m_step = 1;
      end
    end else if (m_stall) begin
      if (rdy) begin
        m_stall = 0; m_pos = HP;
      end
    end else if (m_pos == HP - 1 && !rdy && rw) begin
      m_stall = 1;
    end else if (m_pos == 2 * HP + 1) begin
      if (enable && !m_step) m_pos = 0;
      else begin
        m_run = 0; m_step = 0;
      end
    end else begin
      m_pos = m_pos + 1;
      if (m_pos == 2 * HP + 1) m_cnt = m_cnt + 16'd1;
    end
  endfunction

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, want, $time);
    end
  endfunction

  task automatic tick();
    @(posedge sys_clock);
    #1;
    model_step();
    exp_q.push_back(model_out());
  endtask

  task automatic wait_pos(int target);
    int i;
    for (i = 0; i < 200; i++) begin
      if (m_run && !m_stall && m_pos == target) break;
      tick();
    end
    if (i == 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_pos timeout: target=%0d not reached", target);
    end
  endtask

  // Monitor: compare each DUT cycle against the queued expectation.
  initial begin
    forever begin
      out_t e;
      out_t a;
      @(negedge sys_clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_out();
        check("outputs", 32'(a), 32'(e));
        check("no_overlap", 32'(phase_1 & phase_2), 32'd0);
        check("one_strobe", 32'((32'(phase_1_rising) + 32'(phase_2_rising) + 32'(phase_2_falling)) <= 1), 32'd1);
      end
    end
  end

  // Stimulus.
  initial begin
    logic [15:0] c0;
    repeat (3) tick();
    check("reset_state", 32'(dut_out()), 32'd0);

    // Free run.
    reset  = 1'b1;
    enable = 1'b1;
    repeat (30) tick();
    check("count_after_30", 32'(cycle_count), 32'd3);

    // Read stall for six cycles at the last PHI1 cycle.
    wait_pos(HP - 1);
    rdy = 1'b0; rw = 1'b1;
    repeat (6) tick();
    check("stall_p1_halted", 32'({phase_1, halted, phase_1_rising}), 32'b110);
    rdy = 1'b1;
    repeat (12) tick();

    // Write cycle with rdy low: no stall.
    wait_pos(HP - 1);
    rdy = 1'b0; rw = 1'b0;
    tick();
    check("write_no_stall", 32'({phase_1, halted}), 32'b00);
    repeat (5) tick();
    rdy = 1'b1; rw = 1'b1;
    repeat (10) tick();

    // Stop mid-cycle.
    wait_pos(2);
    enable = 1'b0;
    repeat (15) tick();
    check("stopped_idle", 32'({phase_1, phase_2, halted}), 32'b001);

    // Single step, with a mid-cycle step pulse that must be ignored.
    c0 = m_cnt;
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_pos(3);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (15) tick();
    check("step_count", 32'(cycle_count), 32'(c0 + 16'd1));
    check("step_halted", 32'(halted), 32'd1);

    // Async reset in PHI2.
    enable = 1'b1;
    wait_pos(6);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_out", 32'(dut_out()), 32'd0);
    exp_q.delete();
    model_step();
    exp_q.push_back(model_out());
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("fresh_phi1", 32'({phase_1, phase_1_rising}), 32'b11);
    repeat (12) tick();

    // Counter wrap.
    wait_pos(3);
    force dut.cycle_count_q = 16'hFFFF;
    #1;
    release dut.cycle_count_q;
    m_cnt = 16'hFFFF;
    exp_q[exp_q.size() - 1].cnt = 16'hFFFF;
    wait_pos(2 * HP + 1);
    check("count_wrap", 32'(cycle_count), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 9) < 8);
      step   = ($urandom_range(0, 9) == 0);
      rdy    = ($urandom_range(0, 3) != 0);
      rw     = 1'($urandom);
      tick();
    end

    enable = 1'b0; step = 1'b0; rdy = 1'b1;
    repeat (2) tick();
    @(negedge sys_clock);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
